// File: rtl/step_clk_ctrl.sv
// Processor clock generator for FPGA prototyping: free-run or debounced single-step.
// Optional macro STEP_AUTOREPEAT_EN adds press-and-hold auto-repeat in step mode.
module step_clk_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned RUN_PERIOD      = 50000000,
  parameter int unsigned PULSE_CYCLES    = 25000000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_step,
  input  logic             run_sw,
  output logic             cpu_clk,
  output logic             cpu_tick,
  output logic             busy,
  output logic             mode_run,
  output logic [CNT_W-1:0] tick_count
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RTW = $clog2(RUN_PERIOD + 1);
  localparam int unsigned PCW = $clog2(PULSE_CYCLES + 1);
  localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RTW-1:0] RUN_LAST   = RTW'(RUN_PERIOD - 1);
  localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_CYCLES - 1);

  typedef enum logic {IDLE, HIGH} state_t;

  // Bit 0 carries the step button, bit 1 the run/step mode switch.
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          deb_q, deb_d;
  logic [1:0][DBW-1:0] debCnt_q, debCnt_d;

  logic             btnPrev_q, modePrev_q;
  logic             pending_q, pending_d;
  logic [RTW-1:0]   runTmr_q, runTmr_d;
  state_t           state_q, state_d;
  logic [PCW-1:0]   pulseCnt_q, pulseCnt_d;
  logic             cpuTick_q, cpuTick_d;
  logic [CNT_W-1:0] tickCnt_q, tickCnt_d;

  logic btnDeb, modeRun, modeChange, btnRise, runReq, repReq, stepReq, fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      debCnt_q <= '0;
    end else begin
      sync1_q  <= {run_sw, btn_step};
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      debCnt_q <= debCnt_d;
    end
  end

  // The debounced value only flips after the synced input has disagreed for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    deb_d    = deb_q;
    debCnt_d = '0;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != deb_q[k]) begin
        if (debCnt_q[k] == DEB_LAST) deb_d[k] = ~deb_q[k];
        else                         debCnt_d[k] = debCnt_q[k] + 1'b1;
      end
    end
  end

  assign btnDeb     = deb_q[0];
  assign modeRun    = deb_q[1];
  assign modeChange = modeRun != modePrev_q;
  assign btnRise    = btnDeb & ~btnPrev_q;
  assign runReq     = modeRun && !modeChange && (runTmr_q == RUN_LAST);

`ifdef STEP_AUTOREPEAT_EN
  localparam int unsigned RPW = $clog2(4 * RUN_PERIOD + 1);
  localparam logic [RPW-1:0] REP_FIRE   = RPW'(4 * RUN_PERIOD);
  localparam logic [RPW-1:0] REP_RELOAD = RPW'(3 * RUN_PERIOD + 1);
  logic [RPW-1:0] repCnt_q, repCnt_d;

  // Reload so the next repeat lands exactly RUN_PERIOD cycles after the previous one.
  always_comb begin
    repCnt_d = '0;
    if (btnDeb && !modeRun && !modeChange)
      repCnt_d = (repCnt_q == REP_FIRE) ? REP_RELOAD : repCnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) repCnt_q <= '0;
    else       repCnt_q <= repCnt_d;
  end

  assign repReq = btnDeb && !modeRun && !modeChange && (repCnt_q == REP_FIRE);
`else
  assign repReq = 1'b0;
`endif

  assign stepReq = !modeRun && (btnRise || repReq);

  always_comb begin
    runTmr_d = '0;
    if (modeRun && !modeChange && (runTmr_q != RUN_LAST)) runTmr_d = runTmr_q + 1'b1;
  end

  // cpu_clk is simply "FSM in HIGH"; one pending step survives a pulse, extra ones are absorbed.
  always_comb begin
    state_d    = state_q;
    pulseCnt_d = pulseCnt_q;
    cpuTick_d  = 1'b0;
    tickCnt_d  = tickCnt_q;
    fire       = 1'b0;
    case (state_q)
      IDLE: begin
        if ((pending_q && !modeChange) || runReq) begin
          state_d    = HIGH;
          pulseCnt_d = '0;
          cpuTick_d  = 1'b1;
          tickCnt_d  = tickCnt_q + 1'b1;
          fire       = 1'b1;
        end
      end
      HIGH: begin
        if (pulseCnt_q == PULSE_LAST) state_d = IDLE;
        else                          pulseCnt_d = pulseCnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    pending_d = pending_q;
    if (modeChange)   pending_d = 1'b0;
    else if (stepReq) pending_d = 1'b1;
    else if (fire)    pending_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btnPrev_q  <= 1'b0;
      modePrev_q <= 1'b0;
      pending_q  <= 1'b0;
      runTmr_q   <= '0;
      state_q    <= IDLE;
      pulseCnt_q <= '0;
      cpuTick_q  <= 1'b0;
      tickCnt_q  <= '0;
    end else begin
      btnPrev_q  <= btnDeb;
      modePrev_q <= modeRun;
      pending_q  <= pending_d;
      runTmr_q   <= runTmr_d;
      state_q    <= state_d;
      pulseCnt_q <= pulseCnt_d;
      cpuTick_q  <= cpuTick_d;
      tickCnt_q  <= tickCnt_d;
    end
  end

  assign cpu_clk    = (state_q == HIGH);
  assign busy       = (state_q == HIGH);
  assign cpu_tick   = cpuTick_q;
  assign mode_run   = modeRun;
  assign tick_count = tickCnt_q;

endmodule

// File: tb/tb_step_clk_ctrl.sv
// Directed bench for step_clk_ctrl with small debounce/period values; outputs sampled on the falling edge.
// Defining STEP_AUTOREPEAT_EN also exercises the auto-repeat sequence.
module tb_step_clk_ctrl;

  localparam int DEB = 4;
  localparam int RP  = 10;
  localparam int PC  = 3;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          btnStep;
  logic          runSw;
  logic          cpuClk, cpuTick, busy, modeRun;
  logic [CW-1:0] tickCount;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       btn;
    logic       run;
    logic [7:0] expOut;
  } vec_t;

  vec_t vecs[50];

  step_clk_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .RUN_PERIOD     (RP),
    .PULSE_CYCLES   (PC),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_step  (btnStep),
    .run_sw    (runSw),
    .cpu_clk   (cpuClk),
    .cpu_tick  (cpuTick),
    .busy      (busy),
    .mode_run  (modeRun),
    .tick_count(tickCount)
  );

  always #5 clk = ~clk;

  // Expected output word: {cpu_clk, cpu_tick, busy, mode_run, tick_count}; busy tracks cpu_clk.
  function automatic logic [7:0] mk(input logic c, input logic t, input logic m, input int n);
    logic [3:0] nn;
    nn = n[3:0];
    return {c, t, c, m, nn};
  endfunction

  task automatic checkOutput(input string name, input int idx, input logic [7:0] want);
    logic [7:0] got;
    got = {cpuClk, cpuTick, busy, modeRun, tickCount};
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s[%0d] got=%b want=%b (clk,tick,busy,mode,count)", name, idx, got, want);
    end
  endtask

  task automatic applyStimulus(input logic b, input logic r);
    btnStep = b;
    runSw   = r;
    @(negedge clk);
  endtask

  task automatic doReset();
    reset   = 1'b1;
    btnStep = 1'b0;
    runSw   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset", 0, 8'h00);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ticks;
    int ph;
    logic c, t, m;

    // Five 3-cycle glitches, then a clean 10-cycle press and release.
    for (int i = 0; i < 30; i++) begin
      vecs[i].btn    = ((i % 6) < 3);
      vecs[i].run    = 1'b0;
      vecs[i].expOut = mk(1'b0, 1'b0, 1'b0, 0);
    end
    for (int i = 30; i < 50; i++) begin
      vecs[i].btn    = (i < 40);
      vecs[i].run    = 1'b0;
      vecs[i].expOut = mk((i >= 37 && i <= 39), (i == 37), 1'b0, (i >= 37) ? 1 : 0);
    end

    doReset();
    for (int i = 0; i < 50; i++) begin
      applyStimulus(vecs[i].btn, vecs[i].run);
      checkOutput("step", i, vecs[i].expOut);
    end

    // Run mode: first tick 16 cycles after switching, then every RP; count wraps at 16.
    doReset();
    for (int i = 0; i <= 176; i++) begin
      applyStimulus(1'b0, 1'b1);
      m     = (i >= 5);
      ticks = (i >= 16) ? ((i - 16) / RP + 1) : 0;
      ph    = (i >= 16) ? ((i - 16) % RP) : RP;
      c     = (ph < PC);
      t     = (ph == 0);
      checkOutput("run", i, mk(c, t, m, ticks));
    end

    // cpu_clk is high here; reset must clear it without waiting for a clock edge.
    #2 reset = 1'b1;
    #1 checkOutput("rstMid", 0, 8'h00);
    runSw = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("rstIdle", i, 8'h00);
    end

    // run->step lands during the second run pulse; a press right after becomes pending and fires after the pulse.
    doReset();
    for (int i = 0; i < 60; i++) begin
      applyStimulus((i >= 22), (i <= 20));
      m = (i >= 5 && i <= 25);
      ticks = (i >= 30) ? 3 : (i >= 26) ? 2 : (i >= 16) ? 1 : 0;
      c = (i >= 16 && i <= 18) || (i >= 26 && i <= 28) || (i >= 30 && i <= 32);
      t = (i == 16) || (i == 26) || (i == 30);
      checkOutput("modeSw", i, mk(c, t, m, ticks));
    end

`ifdef STEP_AUTOREPEAT_EN
    // Held press: tick at 7, repeats start 40 cycles after the debounced edge, stop on release.
    doReset();
    for (int i = 0; i < 130; i++) begin
      int tk[$];
      tk = '{7, 47, 57, 67, 77, 87, 97};
      applyStimulus((i < 100), 1'b0);
      ticks = 0;
      c = 1'b0;
      t = 1'b0;
      foreach (tk[j]) begin
        if (tk[j] <= i) ticks++;
        if (i >= tk[j] && i < tk[j] + PC) c = 1'b1;
        if (i == tk[j]) t = 1'b1;
      end
      checkOutput("repeat", i, mk(c, t, 1'b0, ticks));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
